// File: rtl/memory_access.sv
// memory_access -- RV32I memory stage between execute and writeback.
//
// Issues load/store accesses on a req/ack data bus, formats store data and
// byte selects, sign/zero-extends load data and passes all other
// instructions through with one cycle of latency. While an access is in
// flight, or a finished result is parked because writeback is stalled, the
// stage raises stall to hold execute and earlier stages.
//
// Optional build macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned LH/LHU/SH/LW/SW issue no bus access and pass through
//               with LOAD_/STORE_ADDR_MISALIGNED set in exception, rd_w_en = 0.
//   undefined : accesses are never checked; sel is the size mask shifted by
//               a[1:0] and truncated to 4 bits.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   prev_*                   registered outputs of the execute stage
//   prev_clk_en              execute output valid
//   prev_stall               writeback is stalled (outputs must hold)
//   dmem_req/we/addr/wdata/sel  bus request side (held stable until ack)
//   dmem_ack, dmem_rdata     bus completion pulse and read word
//   opcode_type..rd_valid    registered results towards writeback
//   clk_en                   result valid for writeback
//   stall                    combinational hold for earlier stages

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef OPC_LOAD
`define OPC_LOAD 5
`endif
`ifndef OPC_STORE
`define OPC_STORE 6
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif
`ifndef LOAD_ADDR_MISALIGNED
`define LOAD_ADDR_MISALIGNED 2
`endif
`ifndef STORE_ADDR_MISALIGNED
`define STORE_ADDR_MISALIGNED 3
`endif

module memory_access #(
    parameter int DMEM_ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [`OPCODE_WIDTH-1:0]    prev_opcode_type,
    input  logic [2:0]                  prev_funct3,
    input  logic [31:0]                 prev_alu_result,
    input  logic [31:0]                 prev_rs2_data,
    input  logic [4:0]                  prev_rd,
    input  logic [31:0]                 prev_rd_wdata,
    input  logic                        prev_rd_w_en,
    input  logic                        prev_rd_valid,
    input  logic [31:0]                 prev_pc,
    input  logic [`EXCEPTION_WIDTH-1:0] prev_exception,
    input  logic                        prev_clk_en,
    input  logic                        prev_stall,
    output logic                        dmem_req,
    output logic                        dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0]  dmem_addr,
    output logic [31:0]                 dmem_wdata,
    output logic [3:0]                  dmem_sel,
    input  logic                        dmem_ack,
    input  logic [31:0]                 dmem_rdata,
    output logic [`OPCODE_WIDTH-1:0]    opcode_type,
    output logic [2:0]                  funct3,
    output logic [4:0]                  rd,
    output logic [31:0]                 pc,
    output logic [`EXCEPTION_WIDTH-1:0] exception,
    output logic [31:0]                 rd_wdata,
    output logic                        rd_w_en,
    output logic                        rd_valid,
    output logic                        clk_en,
    output logic                        stall
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    // Everything handed to writeback for one instruction.
    typedef struct packed {
        logic [`OPCODE_WIDTH-1:0]    opcode_type;
        logic [2:0]                  funct3;
        logic [4:0]                  rd;
        logic [31:0]                 pc;
        logic [`EXCEPTION_WIDTH-1:0] exception;
        logic [31:0]                 rd_wdata;
        logic                        rd_w_en;
        logic                        rd_valid;
    } wb_t;

    state_t     state, state_next;
    wb_t        out_q, hold_q, pend_q;
    wb_t        pass_w, done_w;
    logic [1:0] pend_off;
    logic       pend_load;

    logic       is_load, is_store, mem_op;
    logic       size_b, size_h;
    logic [1:0] off;
    logic [3:0] sel_base, sel_fmt;
    logic [31:0] wdata_fmt;
    logic [31:0] ld_shift, ld_ext;
    logic       accept, issue_now, pass_now;
`ifdef MEM_MISALIGN_TRAP_EN
    logic       misaligned;
`endif

    // ---------------------------------------------------------------
    // Decode and format the instruction offered by execute
    // ---------------------------------------------------------------
    always_comb begin
        is_load  = prev_opcode_type[`OPC_LOAD];
        is_store = prev_opcode_type[`OPC_STORE];
        off      = prev_alu_result[1:0];

        // Store funct3 1xx is undefined (word); load 1xx are the unsigned forms.
        if (is_store) begin
            size_b = (prev_funct3 == 3'b000);
            size_h = (prev_funct3 == 3'b001);
        end else begin
            size_b = (prev_funct3[1:0] == 2'b00);
            size_h = (prev_funct3[1:0] == 2'b01);
        end

        if (size_b) begin
            sel_base  = 4'b0001;
            wdata_fmt = {4{prev_rs2_data[7:0]}};
        end else if (size_h) begin
            sel_base  = 4'b0011;
            wdata_fmt = {2{prev_rs2_data[15:0]}};
        end else begin
            sel_base  = 4'b1111;
            wdata_fmt = prev_rs2_data;
        end
        sel_fmt = sel_base << off;

        pass_w.opcode_type = prev_opcode_type;
        pass_w.funct3      = prev_funct3;
        pass_w.rd          = prev_rd;
        pass_w.pc          = prev_pc;
        pass_w.exception   = prev_exception;
        pass_w.rd_wdata    = prev_rd_wdata;
        pass_w.rd_w_en     = prev_rd_w_en;
        pass_w.rd_valid    = prev_rd_valid;

        mem_op = is_load || is_store;
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = (size_h && off[0]) || (!size_b && !size_h && (off != 2'b00));
        if (mem_op && misaligned) begin
            mem_op         = 1'b0;
            pass_w.rd_w_en = 1'b0;
            if (is_load)
                pass_w.exception[`LOAD_ADDR_MISALIGNED] = 1'b1;
            else
                pass_w.exception[`STORE_ADDR_MISALIGNED] = 1'b1;
        end
`endif
    end

    // ---------------------------------------------------------------
    // Completion of the outstanding access
    // ---------------------------------------------------------------
    always_comb begin
        ld_shift = dmem_rdata >> {pend_off, 3'b000};
        case (pend_q.funct3[1:0])
            2'b00:   ld_ext = pend_q.funct3[2] ? {24'b0, ld_shift[7:0]}
                                               : {{24{ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_ext = pend_q.funct3[2] ? {16'b0, ld_shift[15:0]}
                                               : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase

        done_w = pend_q;
        if (pend_load) begin
            done_w.rd_wdata = ld_ext;
            done_w.rd_valid = 1'b1;
        end else begin
            done_w.rd_w_en  = 1'b0;
        end
    end

    // Stall falls in the ack cycle, so execute advances on the completing
    // edge and the instruction it was holding must be taken on that edge.
    assign stall     = prev_stall || (state == WAIT && !dmem_ack) || (state == HOLD);
    assign accept    = prev_clk_en && !stall;
    assign issue_now = accept && mem_op;
    assign pass_now  = accept && !mem_op;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (issue_now) state_next = WAIT;
            WAIT: begin
                if (dmem_ack) begin
                    if (prev_stall)     state_next = HOLD;
                    else if (issue_now) state_next = WAIT;
                    // A passthrough taken on the completion edge waits one
                    // cycle in the holding register behind the finished access.
                    else if (pass_now)  state_next = HOLD;
                    else                state_next = IDLE;
                end
            end
            HOLD: if (!prev_stall) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Bus, pending, holding and output registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_sel   <= '0;
            pend_q     <= '0;
            pend_off   <= '0;
            pend_load  <= 1'b0;
            hold_q     <= '0;
            out_q      <= '0;
            clk_en     <= 1'b0;
        end else begin
            if (issue_now) begin
                dmem_req   <= 1'b1;
                dmem_we    <= is_store;
                dmem_addr  <= {prev_alu_result[DMEM_ADDR_WIDTH-1:2], 2'b00};
                dmem_wdata <= wdata_fmt;
                dmem_sel   <= sel_fmt;
                pend_q     <= pass_w;
                pend_off   <= off;
                pend_load  <= is_load;
            end else if (state == WAIT && dmem_ack) begin
                dmem_req   <= 1'b0;
            end

            if (state == WAIT && dmem_ack && prev_stall)
                hold_q <= done_w;
            else if (state == WAIT && pass_now)
                hold_q <= pass_w;

            if (state == WAIT && dmem_ack && !prev_stall) begin
                out_q  <= done_w;
                clk_en <= 1'b1;
            end else if (state == HOLD && !prev_stall) begin
                out_q  <= hold_q;
                clk_en <= 1'b1;
            end else if (state == IDLE && pass_now) begin
                out_q  <= pass_w;
                clk_en <= 1'b1;
            end else if (!prev_stall) begin
                clk_en <= 1'b0;
            end
        end
    end

    assign opcode_type = out_q.opcode_type;
    assign funct3      = out_q.funct3;
    assign rd          = out_q.rd;
    assign pc          = out_q.pc;
    assign exception   = out_q.exception;
    assign rd_wdata    = out_q.rd_wdata;
    assign rd_w_en     = out_q.rd_w_en;
    assign rd_valid    = out_q.rd_valid;

endmodule
